// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the data-memory responder.
package dmem_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // Little-endian lanes: lane 0 is bits [7:0].
   function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_word,
                                                    input logic [7:0]        byte_val,
                                                    input logic [1:0]        lane);
      logic [DATA_W-1:0] w;
      w = old_word;
      case (lane)
         2'd0:    w[7:0]   = byte_val;
         2'd1:    w[15:8]  = byte_val;
         2'd2:    w[23:16] = byte_val;
         default: w[31:24] = byte_val;
      endcase
      return w;
   endfunction

   function automatic logic [7:0] lane_extract(input logic [DATA_W-1:0] word,
                                               input logic [1:0]        lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: combinational read, one synchronous full-word write.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle handshaked data memory for LDR/STR/LDRB/STRB with programmable wait states.
// Optional DMEM_BOUNDS_CHECK_EN faults addresses at or above 4*DEPTH bytes.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request held, counting down wait states
// RESP  | rsp_valid pulse; a store commits on the edge that ends this cycle
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_byte,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   dmem_state_t state, next_state;
   logic [CNT_W-1:0]  cnt;
   logic              lat_we, lat_byte;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              accept;
   logic              c_we, c_byte;
   logic [ADDR_W-1:0] c_addr;
   logic [IDX_W-1:0]  c_idx;
   logic [1:0]        c_lane;
   logic              c_misaligned, c_oob, c_err;
   logic [DATA_W-1:0] rsp_d;

   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata, arr_rdata;

   // In IDLE the incoming request is the one being evaluated, so a zero-wait
   // access can register its response on the accept edge; elsewhere use the latch.
   always_comb begin
      c_we   = lat_we;
      c_byte = lat_byte;
      c_addr = lat_addr;
      if (state == IDLE) begin
         c_we   = req_we;
         c_byte = req_byte;
         c_addr = req_addr;
      end
   end

   assign c_idx        = c_addr[IDX_W+1:2];
   assign c_lane       = c_addr[1:0];
   assign c_misaligned = !c_byte && (c_lane != 2'b00);

`ifdef DMEM_BOUNDS_CHECK_EN
   assign c_oob = |c_addr[ADDR_W-1:IDX_W+2];
`else
   logic unused_addr_bits;
   assign c_oob            = 1'b0;
   assign unused_addr_bits = ^c_addr[ADDR_W-1:IDX_W+2];
`endif

   assign c_err  = c_misaligned || c_oob;
   assign accept = req_valid && req_ready;

   always_comb begin
      rsp_d = '0;
      if (!c_we && !c_err)
         rsp_d = c_byte ? {24'b0, lane_extract(arr_rdata, c_lane)} : arr_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (req_valid) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT: if (cnt == CNT_ONE) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      mem_we    = (state == RESP) && lat_we && !c_err && !reset;
      mem_wdata = lat_byte ? lane_merge(arr_rdata, lat_wdata[7:0], c_lane) : lat_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_byte  <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            lat_we    <= req_we;
            lat_byte  <= req_byte;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= WS_INIT;
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_ONE;
         end
         if (next_state == RESP) begin
            rsp_rdata <= rsp_d;
            rsp_err   <= c_err;
         end
      end
   end

   dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (c_idx),
      .wdata (mem_wdata),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with 2 wait states, one with none for the handshake test.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, req_byte;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid_0, req_we_0, req_byte_0;
   logic [31:0] req_addr_0, req_wdata_0;
   logic        req_ready_0, rsp_valid_0, rsp_err_0;
   logic [31:0] rsp_rdata_0;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_0), .req_ready(req_ready_0), .req_we(req_we_0), .req_byte(req_byte_0),
      .req_addr(req_addr_0), .req_wdata(req_wdata_0),
      .rsp_valid(rsp_valid_0), .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge with dut idle; returns just after a rising edge.
   task automatic do_req(input string tag, input logic we, input logic bt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int   lat;
      logic rdy;
      logic acc;
      logic got;
      req_valid = 1'b1;
      req_we    = we;
      req_byte  = bt;
      req_addr  = addr;
      req_wdata = wdata;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         acc = rdy;
      end
      #1 req_valid = 1'b0;
      chk({tag, " accept"}, {31'b0, acc}, 32'd1);
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         lat++;
         got = rsp_valid;
      end
      chk({tag, " latency"}, 32'(lat), 32'd3);
      chk({tag, " ready_in_resp"}, {31'b0, req_ready}, 32'd0);
      chk({tag, " rdata"}, rsp_rdata, exp_rdata);
      chk({tag, " err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      @(negedge clk);
      chk({tag, " pulse_end"}, {31'b0, rsp_valid}, 32'd0);
      chk({tag, " ready_after"}, {31'b0, req_ready}, 32'd1);
      chk({tag, " rdata_hold"}, rsp_rdata, exp_rdata);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   n_acc, n_rsp, n_both, n_consec;
      logic prev_rsp, any_rsp;

      reset       = 1'b1;
      req_valid   = 1'b0; req_we   = 1'b0; req_byte   = 1'b0; req_addr   = '0; req_wdata   = '0;
      req_valid_0 = 1'b0; req_we_0 = 1'b0; req_byte_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("reset ready", {31'b0, req_ready}, 32'd1);
      chk("reset valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset rdata", rsp_rdata, 32'd0);
      chk("reset err", {31'b0, rsp_err}, 32'd0);
      chk("reset ready0", {31'b0, req_ready_0}, 32'd1);
      @(posedge clk);
      #1;

      // word write/read
      do_req("st100", 1'b1, 1'b0, 32'd100, 32'h0000_0007, 32'h0, 1'b0);
      do_req("ld100", 1'b0, 1'b0, 32'd100, 32'h0,         32'h0000_0007, 1'b0);

      // byte lanes
      do_req("st96",  1'b1, 1'b0, 32'd96, 32'h1122_3344, 32'h0, 1'b0);
      do_req("stb98", 1'b1, 1'b1, 32'd98, 32'hFFFF_FFAB, 32'h0, 1'b0);
      do_req("ld96",  1'b0, 1'b0, 32'd96, 32'h0, 32'h11AB_3344, 1'b0);
      do_req("ldb97", 1'b0, 1'b1, 32'd97, 32'h0, 32'h0000_0033, 1'b0);
      do_req("ldb98", 1'b0, 1'b1, 32'd98, 32'h0, 32'h0000_00AB, 1'b0);

      // misaligned
      do_req("st64",  1'b1, 1'b0, 32'd64, 32'h0102_0304, 32'h0, 1'b0);
      do_req("st66",  1'b1, 1'b0, 32'd66, 32'hDEAD_BEEF, 32'h0, 1'b1);
      do_req("ld64",  1'b0, 1'b0, 32'd64, 32'h0, 32'h0102_0304, 1'b0);
      do_req("ld65",  1'b0, 1'b0, 32'd65, 32'h0, 32'h0, 1'b1);

      // reset during WAIT abandons the store
      do_req("st8pre", 1'b1, 1'b0, 32'd8, 32'h0000_1234, 32'h0, 1'b0);
      req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'd8; req_wdata = 32'h5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("rst wait_valid", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst ready", {31'b0, req_ready}, 32'd1);
      any_rsp = rsp_valid;
      repeat (4) begin
         @(negedge clk);
         any_rsp = any_rsp | rsp_valid;
      end
      chk("rst no_rsp", {31'b0, any_rsp}, 32'd0);
      @(posedge clk);
      #1;
      do_req("ld8", 1'b0, 1'b0, 32'd8, 32'h0, 32'h0000_1234, 1'b0);

      // bounds
      do_req("st0", 1'b1, 1'b0, 32'd0, 32'hCAFE_F00D, 32'h0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
      do_req("ld100h", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
      do_req("st100h", 1'b1, 1'b0, 32'h100, 32'h0000_0099, 32'h0, 1'b1);
      do_req("ld0",    1'b0, 1'b0, 32'd0, 32'h0, 32'hCAFE_F00D, 1'b0);
`else
      do_req("ld100h", 1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0);
      do_req("st100h", 1'b1, 1'b0, 32'h100, 32'h0000_0099, 32'h0, 1'b0);
      do_req("ld0",    1'b0, 1'b0, 32'd0, 32'h0, 32'h0000_0099, 1'b0);
`endif

      // zero-wait handshake with req_valid held high for 10 cycles
      req_valid_0 = 1'b1; req_we_0 = 1'b0; req_byte_0 = 1'b0; req_addr_0 = 32'd4;
      n_acc = 0; n_rsp = 0; n_both = 0; n_consec = 0; prev_rsp = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req_ready_0) n_acc++;
         if (rsp_valid_0) n_rsp++;
         if (req_ready_0 && rsp_valid_0) n_both++;
         if (rsp_valid_0 && prev_rsp) n_consec++;
         prev_rsp = rsp_valid_0;
      end
      @(posedge clk);
      #1 req_valid_0 = 1'b0;
      chk("hs accepts", 32'(n_acc), 32'd5);
      chk("hs responses", 32'(n_rsp), 32'd5);
      chk("hs ready_in_resp", 32'(n_both), 32'd0);
      chk("hs pulse_width", 32'(n_consec), 32'd0);
      chk("hs err", {31'b0, rsp_err_0}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
